jtag_scan_master: RTL and testbench

JTAG_SCAN_MASTER -- requirements
Module: jtag_scan_master

---
 rtl/jtag.sv | 48 ++++
 rtl/jtag_tck_gen.sv | 42 ++++
 rtl/jtag_scan_master.sv | 159 +++++++++++++++
 tb/tb_jtag_scan_master.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtag.sv
// Shared JTAG definitions: IEEE 1149.1 TAP states and transition function,
// scan-master command opcodes, FSM states and the IR codes used with the target.
package jtag;

    typedef enum logic [3:0] {
        TEST_LOGIC_RESET, RUN_TEST_IDLE,
        SELECT_DR, CAPTURE_DR, SHIFT_DR, EXIT1_DR, PAUSE_DR, EXIT2_DR, UPDATE_DR,
        SELECT_IR, CAPTURE_IR, SHIFT_IR, EXIT1_IR, PAUSE_IR, EXIT2_IR, UPDATE_IR
    } jtag_state_t;

    typedef enum logic [1:0] {
        OP_TLR = 2'd0,
        OP_IR  = 2'd1,
        OP_DR  = 2'd2,
        OP_NOP = 2'd3
    } jtag_op_t;

    typedef enum logic [2:0] {
        IDLE, TLR, WALK_IN, SHIFT, WALK_OUT, RESP
    } scan_fsm_t;

    localparam logic [5:0] IR_IDCODE = 6'h01;
    localparam logic [5:0] IR_SAMPLE = 6'h00;

    function automatic jtag_state_t tap_next(input jtag_state_t s, input logic tms);
        jtag_state_t n;
        case (s)
            TEST_LOGIC_RESET: n = tms ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
            RUN_TEST_IDLE:    n = tms ? SELECT_DR        : RUN_TEST_IDLE;
            SELECT_DR:        n = tms ? SELECT_IR        : CAPTURE_DR;
            CAPTURE_DR:       n = tms ? EXIT1_DR         : SHIFT_DR;
            SHIFT_DR:         n = tms ? EXIT1_DR         : SHIFT_DR;
            EXIT1_DR:         n = tms ? UPDATE_DR        : PAUSE_DR;
            PAUSE_DR:         n = tms ? EXIT2_DR         : PAUSE_DR;
            EXIT2_DR:         n = tms ? UPDATE_DR        : SHIFT_DR;
            UPDATE_DR:        n = tms ? SELECT_DR        : RUN_TEST_IDLE;
            SELECT_IR:        n = tms ? TEST_LOGIC_RESET : CAPTURE_IR;
            CAPTURE_IR:       n = tms ? EXIT1_IR         : SHIFT_IR;
            SHIFT_IR:         n = tms ? EXIT1_IR         : SHIFT_IR;
            EXIT1_IR:         n = tms ? UPDATE_IR        : PAUSE_IR;
            PAUSE_IR:         n = tms ? EXIT2_IR         : PAUSE_IR;
            EXIT2_IR:         n = tms ? UPDATE_IR        : SHIFT_IR;
            default:          n = tms ? SELECT_DR        : RUN_TEST_IDLE;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/jtag_tck_gen.sv
// TCK divider: tclk toggles every DIV clk cycles while enabled, parked low otherwise.
// The first terminal count after enable is a "fall" that only sets up TMS/TDI.
module jtag_tck_gen #(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic trst,
    input  logic en_i,
    output logic tclk_o,
    output logic rise_stb_o,
    output logic fall_stb_o
);

    logic [7:0] cnt_q;
    logic       tclk_q;
    logic       primed_q;
    logic       tc;

    assign tc         = en_i && (cnt_q == 8'(DIV - 1));
    assign rise_stb_o = tc && primed_q && !tclk_q;
    assign fall_stb_o = tc && (tclk_q || !primed_q);
    assign tclk_o     = tclk_q;

    always_ff @(posedge clk or negedge trst) begin
        if (!trst) begin
            cnt_q    <= 8'd0;
            tclk_q   <= 1'b0;
            primed_q <= 1'b0;
        end else if (!en_i) begin
            cnt_q    <= 8'd0;
            tclk_q   <= 1'b0;
            primed_q <= 1'b0;
        end else if (tc) begin
            cnt_q    <= 8'd0;
            primed_q <= 1'b1;
            tclk_q   <= rise_stb_o;
        end else begin
            cnt_q    <= cnt_q + 8'd1;
        end
    end

endmodule

// File: rtl/jtag_scan_master.sv
// JTAG scan master: runs TLR / IR / DR sequences on a target TAP, keeping a
// mirror of the TAP state and returning captured TDO right-justified.
module jtag_scan_master
    import jtag::*;
#(
    parameter int DIV    = 2,
    parameter int IR_LEN = 6
) (
    input  logic        clk,
    input  logic        trst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [5:0]  cmd_len,
    input  logic [31:0] cmd_data,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        tclk,
    output logic        tms,
    output logic        tdi,
    input  logic        tdo
);

    localparam logic [5:0] IR_N = 6'(IR_LEN);

    scan_fsm_t   state_q, state_d;
    jtag_state_t tap_q, tap_d;
    jtag_op_t    op_q, op_d;
    logic        tms_q, tms_d, tdi_q, tdi_d;
    logic [5:0]  n_q, n_d, cnt_q, cnt_d;
    logic [31:0] data_q, data_d, sr_q, sr_d, rsp_q, rsp_d;
    logic        rise_stb, fall_stb, tck_en;
    logic        bit_tms, last;

    assign tck_en    = (state_q == TLR) || (state_q == WALK_IN) ||
                       (state_q == SHIFT) || (state_q == WALK_OUT);
    assign cmd_ready = (state_q == IDLE) || (state_q == RESP);
    assign rsp_valid = (state_q == RESP);
    assign rsp_data  = rsp_q;
    assign tms       = tms_q;
    assign tdi       = tdi_q;

    jtag_tck_gen #(.DIV(DIV)) u_tck (
        .clk        (clk),
        .trst       (trst),
        .en_i       (tck_en),
        .tclk_o     (tclk),
        .rise_stb_o (rise_stb),
        .fall_stb_o (fall_stb)
    );

    always_comb begin
        state_d = state_q;
        tap_d   = tap_q;
        op_d    = op_q;
        tms_d   = tms_q;
        tdi_d   = tdi_q;
        n_d     = n_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        sr_d    = sr_q;
        rsp_d   = rsp_q;
        bit_tms = 1'b0;
        last    = 1'b0;

        // TMS for the bit currently being presented, and whether it ends the phase
        case (state_q)
            TLR: begin
                bit_tms = (cnt_q != 6'd5);
                last    = (cnt_q == 6'd5);
            end
            WALK_IN: begin
                if (op_q == OP_IR) begin
                    bit_tms = (cnt_q < 6'd2);
                    last    = (cnt_q == 6'd3);
                end else begin
                    bit_tms = (cnt_q == 6'd0);
                    last    = (cnt_q == 6'd2);
                end
            end
            SHIFT: begin
                bit_tms = (cnt_q == n_q - 6'd1);
                last    = bit_tms;
            end
            WALK_OUT: begin
                bit_tms = (cnt_q == 6'd0);
                last    = (cnt_q == 6'd1);
            end
            default: ;
        endcase

        if (fall_stb) begin
            tms_d = bit_tms;
            tdi_d = (state_q == SHIFT) ? data_q[cnt_q[4:0]] : 1'b0;
        end

        if (rise_stb) begin
            tap_d = tap_next(tap_q, tms_q);
            cnt_d = last ? 6'd0 : cnt_q + 6'd1;
            if (state_q == SHIFT)
                sr_d = {tdo, sr_q[31:1]};
            if (last) begin
                case (state_q)
                    TLR:      state_d = IDLE;
                    WALK_IN:  state_d = SHIFT;
                    SHIFT:    state_d = WALK_OUT;
                    WALK_OUT: begin
                        state_d = RESP;
                        rsp_d   = sr_q >> (6'd32 - n_q);
                    end
                    default: ;
                endcase
            end
        end

        if (state_q == RESP)
            state_d = IDLE;

        // Accepting in RESP gives back-to-back scans; an illegal op just stays idle.
        if (cmd_ready && cmd_valid) begin
            op_d   = jtag_op_t'(cmd_op);
            data_d = cmd_data;
            cnt_d  = 6'd0;
            n_d    = (cmd_op == OP_IR) ? IR_N : ((cmd_len == 6'd0) ? 6'd32 : cmd_len);
            case (jtag_op_t'(cmd_op))
                OP_TLR:       state_d = TLR;
                OP_IR, OP_DR: state_d = WALK_IN;
                default:      state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge trst) begin
        if (!trst) begin
            state_q <= TLR;
            tap_q   <= TEST_LOGIC_RESET;
            op_q    <= OP_TLR;
            tms_q   <= 1'b1;
            tdi_q   <= 1'b0;
            n_q     <= 6'd0;
            cnt_q   <= 6'd0;
            data_q  <= 32'd0;
            sr_q    <= 32'd0;
            rsp_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            tap_q   <= tap_d;
            op_q    <= op_d;
            tms_q   <= tms_d;
            tdi_q   <= tdi_d;
            n_q     <= n_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            sr_q    <= sr_d;
            rsp_q   <= rsp_d;
        end
    end

endmodule

// File: tb/tb_jtag_scan_master.sv
// Bench for jtag_scan_master: a behavioural TAP target (IDCODE / SAMPLE / BYPASS)
// driven by the DUT, a table of directed commands, random commands and a reset abort.
module tb_jtag_scan_master;
    import jtag::*;

    logic        clk = 1'b0;
    logic        trst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [5:0]  cmd_len;
    logic [31:0] cmd_data;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        tclk, tms, tdi;
    logic        tdo = 1'b0;

    int nvec = 0;
    int nerr = 0;
    int rises = 0;
    int rsp_cnt = 0;
    int r0, rsp0;

    jtag_scan_master #(.DIV(1), .IR_LEN(6)) dut (
        .clk(clk), .trst(trst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_len(cmd_len), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .tclk(tclk), .tms(tms), .tdi(tdi), .tdo(tdo)
    );

    always #5 clk = ~clk;

    always @(posedge tclk) rises <= rises + 1;
    always @(posedge clk) if (rsp_valid) rsp_cnt <= rsp_cnt + 1;

    // ---------------- behavioural target TAP (not reset by trst) ----------------
    jtag_state_t tst = SHIFT_DR;
    logic [5:0]  tir = 6'h2A;
    logic [5:0]  tir_sr = 6'h0;
    logic [31:0] tsr = 32'h0;
    logic [31:0] nsr;
    int          tlen = 1;

    function automatic jtag_state_t tap_step(input jtag_state_t s, input logic m);
        case (s)
            TEST_LOGIC_RESET: return m ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
            RUN_TEST_IDLE:    return m ? SELECT_DR : RUN_TEST_IDLE;
            SELECT_DR:        return m ? SELECT_IR : CAPTURE_DR;
            CAPTURE_DR, SHIFT_DR: return m ? EXIT1_DR : SHIFT_DR;
            EXIT1_DR:         return m ? UPDATE_DR : PAUSE_DR;
            PAUSE_DR:         return m ? EXIT2_DR : PAUSE_DR;
            EXIT2_DR:         return m ? UPDATE_DR : SHIFT_DR;
            SELECT_IR:        return m ? TEST_LOGIC_RESET : CAPTURE_IR;
            CAPTURE_IR, SHIFT_IR: return m ? EXIT1_IR : SHIFT_IR;
            EXIT1_IR:         return m ? UPDATE_IR : PAUSE_IR;
            PAUSE_IR:         return m ? EXIT2_IR : PAUSE_IR;
            EXIT2_IR:         return m ? UPDATE_IR : SHIFT_IR;
            default:          return m ? SELECT_DR : RUN_TEST_IDLE;
        endcase
    endfunction

    always @(posedge tclk) begin
        case (tst)
            TEST_LOGIC_RESET: tir <= IR_IDCODE;
            CAPTURE_DR: begin
                tsr  <= (tir == IR_IDCODE) ? 32'h1BEEF001 :
                        (tir == IR_SAMPLE) ? 32'h55555555 : 32'h0;
                tlen <= (tir == IR_IDCODE || tir == IR_SAMPLE) ? 32 : 1;
            end
            SHIFT_DR: begin
                nsr = tsr >> 1;
                nsr[tlen-1] = tdi;
                tsr <= nsr;
            end
            CAPTURE_IR: tir_sr <= 6'b000001;
            SHIFT_IR:   tir_sr <= {tdi, tir_sr[5:1]};
            UPDATE_IR:  tir <= tir_sr;
            default: ;
        endcase
        tst <= tap_step(tst, tms);
    end

    always @(negedge tclk)
        tdo <= (tst == SHIFT_DR) ? tsr[0] : (tst == SHIFT_IR) ? tir_sr[0] : 1'b0;

    // ---------------- register-level reference model ----------------
    logic [5:0] ir_m = IR_IDCODE;

    task automatic model(input jtag_op_t op, input logic [5:0] len, input logic [31:0] data,
                         output logic rsp, output logic [31:0] val, output int nr);
        int n;
        logic [31:0] regv;
        n = (len == 6'd0) ? 32 : int'(len);
        rsp = 1'b0; val = 32'h0; nr = 0;
        case (op)
            OP_TLR: begin ir_m = IR_IDCODE; nr = 6; end
            OP_IR: begin rsp = 1'b1; val = 32'h1; nr = 4 + 6 + 2; ir_m = data[5:0]; end
            OP_DR: begin
                if (ir_m == IR_IDCODE)      regv = 32'h1BEEF001;
                else if (ir_m == IR_SAMPLE) regv = 32'h55555555;
                else                        regv = {data[30:0], 1'b0};
                val = (n == 32) ? regv : (regv & ((32'h1 << n) - 32'h1));
                rsp = 1'b1;
                nr  = 3 + n + 2;
            end
            default: ;
        endcase
    endtask

    // ---------------- checking helpers ----------------
    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h", nm, got, exp);
        end
    endtask

    task automatic send(input jtag_op_t op, input logic [5:0] len, input logic [31:0] data);
        int w = 0;
        while (!cmd_ready && w < 500) begin @(negedge clk); w++; end
        if (!cmd_ready) begin
            nvec++; nerr++;
            $display("FAIL ready_timeout: cmd_ready low for %0d clk, needed high", w);
        end
        cmd_valid = 1'b1; cmd_op = op; cmd_len = len; cmd_data = data;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_op = 2'($urandom); cmd_len = 6'($urandom); cmd_data = $urandom;
        r0 = rises; rsp0 = rsp_cnt;
    endtask

    task automatic wait_done(output logic got, output logic [31:0] dat, output logic rdy1);
        int c = 0;
        logic fin = 1'b0;
        got = 1'b0; dat = 32'h0; rdy1 = 1'b0;
        while (!fin && c < 500) begin
            @(negedge clk);
            if (c == 0) rdy1 = cmd_ready;
            c++;
            if (rsp_valid) begin got = 1'b1; dat = rsp_data; fin = 1'b1; end
            else if (cmd_ready) fin = 1'b1;
        end
        if (!fin) begin
            nvec++; nerr++;
            $display("FAIL done_timeout: no completion in %0d clk, needed one", c);
        end
    endtask

    task automatic do_cmd(input jtag_op_t op, input logic [5:0] len, input logic [31:0] data,
                          input logic exp_rsp, input logic [31:0] exp_dat, input int exp_rises);
        logic got, rdy1;
        logic [31:0] dat;
        send(op, len, data);
        wait_done(got, dat, rdy1);
        chk("ready_after_accept", 32'(rdy1), 32'(op == OP_NOP));
        chk("rsp_valid", 32'(got), 32'(exp_rsp));
        if (exp_rsp) chk("rsp_data", dat, exp_dat);
        chk("tclk_rises", 32'(rises - r0), 32'(exp_rises));
        chk("early_rsp_pulses", 32'(rsp_cnt - rsp0), 32'h0);
        chk("mirror", 32'(dut.tap_q), 32'(RUN_TEST_IDLE));
        chk("target_state", 32'(tst), 32'(RUN_TEST_IDLE));
    endtask

    typedef struct {
        jtag_op_t    op;
        logic [5:0]  len;
        logic [31:0] data;
        logic        rsp;
        logic [31:0] exp;
        int          nr;
    } vec_t;

    vec_t tv[14];

    initial begin
        logic mr;
        logic [31:0] mv;
        int mn, w, idle_hi;

        tv[0]  = '{OP_DR,  6'd0,  32'h0,        1'b1, 32'h1BEEF001, 37};
        tv[1]  = '{OP_IR,  6'd0,  32'h0000002A, 1'b1, 32'h00000001, 12};
        tv[2]  = '{OP_DR,  6'd32, 32'h0,        1'b1, 32'h00000000, 37};
        tv[3]  = '{OP_DR,  6'd4,  32'h0000000B, 1'b1, 32'h00000006, 9};
        tv[4]  = '{OP_DR,  6'd32, 32'hDEADBEEF, 1'b1, 32'hBD5B7DDE, 37};
        tv[5]  = '{OP_IR,  6'd9,  32'h00000000, 1'b1, 32'h00000001, 12};
        tv[6]  = '{OP_DR,  6'd32, 32'h0,        1'b1, 32'h55555555, 37};
        tv[7]  = '{OP_DR,  6'd8,  32'h000000FF, 1'b1, 32'h00000055, 13};
        tv[8]  = '{OP_TLR, 6'd0,  32'h0,        1'b0, 32'h0,        6};
        tv[9]  = '{OP_DR,  6'd1,  32'h0,        1'b1, 32'h00000001, 6};
        tv[10] = '{OP_NOP, 6'd5,  32'h12345678, 1'b0, 32'h0,        0};
        tv[11] = '{OP_DR,  6'd16, 32'h0,        1'b1, 32'h0000F001, 21};
        tv[12] = '{OP_IR,  6'd0,  32'h00000001, 1'b1, 32'h00000001, 12};
        tv[13] = '{OP_DR,  6'd0,  32'h0,        1'b1, 32'h1BEEF001, 37};

        trst = 1'b0; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_len = 6'd0; cmd_data = 32'h0;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_tclk", 32'(tclk), 32'h0);
        chk("rst_tms", 32'(tms), 32'h1);
        chk("rst_tdi", 32'(tdi), 32'h0);
        chk("rst_ready", 32'(cmd_ready), 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_rsp_data", rsp_data, 32'h0);
        chk("rst_mirror", 32'(dut.tap_q), 32'(TEST_LOGIC_RESET));

        // automatic TLR after release
        trst = 1'b1;
        r0 = rises;
        w = 0;
        while (!cmd_ready && w < 200) begin @(negedge clk); w++; end
        chk("init_ready", 32'(cmd_ready), 32'h1);
        chk("init_rises", 32'(rises - r0), 32'h6);
        chk("init_mirror", 32'(dut.tap_q), 32'(RUN_TEST_IDLE));
        chk("init_target", 32'(tst), 32'(RUN_TEST_IDLE));
        chk("init_target_ir", 32'(tir), 32'(IR_IDCODE));

        // directed table
        for (int i = 0; i < 14; i++) begin
            model(tv[i].op, tv[i].len, tv[i].data, mr, mv, mn);
            do_cmd(tv[i].op, tv[i].len, tv[i].data, tv[i].rsp, tv[i].exp, tv[i].nr);
        end
        chk("ir_after_sample_sel", 32'(tir), 32'(IR_IDCODE));

        // response is a single pulse, data held, tclk parked low while idle
        @(negedge clk);
        chk("rsp_pulse_width", 32'(rsp_valid), 32'h0);
        chk("rsp_held", rsp_data, 32'h1BEEF001);
        r0 = rises; idle_hi = 0;
        repeat (8) begin @(negedge clk); if (tclk) idle_hi++; end
        chk("idle_tclk_high", 32'(idle_hi), 32'h0);
        chk("idle_rises", 32'(rises - r0), 32'h0);
        model(OP_TLR, 6'd0, 32'h0, mr, mv, mn);
        do_cmd(OP_TLR, 6'd0, 32'h0, 1'b0, 32'h0, 6);
        chk("rsp_held_after_tlr", rsp_data, 32'h1BEEF001);

        // random commands against the model
        for (int i = 0; i < 40; i++) begin
            jtag_op_t    op;
            logic [5:0]  len;
            logic [31:0] data;
            op   = jtag_op_t'($urandom_range(0, 3));
            len  = 6'($urandom_range(0, 32));
            data = $urandom;
            if (op == OP_IR) begin
                case ($urandom_range(0, 2))
                    0: data[5:0] = IR_SAMPLE;
                    1: data[5:0] = IR_IDCODE;
                    default: ;
                endcase
            end
            model(op, len, data, mr, mv, mn);
            do_cmd(op, len, data, mr, mv, mn);
        end

        // reset asserted in the middle of SHIFT_DR
        send(OP_DR, 6'd32, 32'h0);
        w = 0;
        while (!(tst == SHIFT_DR && rises - r0 >= 10) && w < 300) begin @(negedge clk); w++; end
        chk("abort_in_shift", 32'(tst), 32'(SHIFT_DR));
        rsp0 = rsp_cnt;
        trst = 1'b0;
        #1;
        chk("abort_tms", 32'(tms), 32'h1);
        chk("abort_tclk", 32'(tclk), 32'h0);
        chk("abort_ready", 32'(cmd_ready), 32'h0);
        repeat (3) @(negedge clk);
        trst = 1'b1;
        r0 = rises;
        w = 0;
        while (!cmd_ready && w < 200) begin @(negedge clk); w++; end
        chk("abort_no_rsp", 32'(rsp_cnt - rsp0), 32'h0);
        chk("abort_tlr_rises", 32'(rises - r0), 32'h6);
        chk("abort_target", 32'(tst), 32'(RUN_TEST_IDLE));
        ir_m = IR_IDCODE;
        model(OP_DR, 6'd0, 32'h0, mr, mv, mn);
        do_cmd(OP_DR, 6'd0, 32'h0, mr, mv, mn);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
